// File: rtl/demux_dispatch_sched.sv
// demux_dispatch_sched: upstream feeder for the 1:4 demux stage.
// Buffers destination requests in a DEPTH-entry FIFO and issues each one as
// a registered one-cycle inp pulse with a matching sel. At least GAP_CYCLES
// inp-low cycles separate consecutive pulses.
// Optional macro DISPATCH_CNT_EN adds disp_cnt: four 8-bit saturating
// per-channel pulse counters ([7:0] ch0 .. [31:24] ch3).
module demux_dispatch_sched #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [1:0]               in_dest,
  output logic                     in_ready,
  output logic [1:0]               sel,
  output logic                     inp,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
`ifdef DISPATCH_CNT_EN
  ,
  output logic [31:0]              disp_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Gap counter only has to hold GAP_CYCLES-1; keep at least one bit.
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  logic [DEPTH-1:0][1:0] mem;
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;
  state_t                state, state_n;
  logic [GW-1:0]         gap_cnt, gap_n;
  logic                  push, pop, can_issue;
  logic [1:0]            head;

  assign in_ready   = (count != CW'(DEPTH)) && !flush;
  assign push       = in_valid && in_ready;
  assign head       = mem[rptr];
  // Uses registered occupancy, so an entry pushed this edge pops next edge at earliest.
  assign can_issue  = en && (count != '0);
  assign fifo_count = count;
  assign busy       = (state != IDLE) || (count != '0);

  // FIFO storage write; no reset needed, pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_dest;
  end

  // FIFO pointers and occupancy; flush clears, push+pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state, gap counter and registered demux drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
      sel     <= 2'b00;
      inp     <= 1'b0;
    end else if (flush) begin
      // sel deliberately holds its last issued value
      state   <= IDLE;
      gap_cnt <= '0;
      inp     <= 1'b0;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_n;
      inp     <= pop;
      if (pop) sel <= head;
    end
  end

  // Next-state logic; every pop is also an issue.
  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (can_issue) begin
          pop     = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (GAP_CYCLES == 0) begin
          if (can_issue) pop = 1'b1;
          else           state_n = IDLE;
        end else begin
          gap_n   = GW'(GAP_CYCLES - 1);
          state_n = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          if (can_issue) begin
            pop     = 1'b1;
            state_n = ISSUE;
          end else begin
            state_n = IDLE;
          end
        end else begin
          gap_n = gap_cnt - GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef DISPATCH_CNT_EN
  logic [3:0][7:0] dcnt;

  // Per-channel pulse counters, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      dcnt <= '0;
    end else if (pop && (dcnt[head] != 8'hFF)) begin
      dcnt[head] <= dcnt[head] + 8'd1;
    end
  end

  assign disp_cnt = dcnt;
`endif

endmodule

// File: tb/tb_demux_dispatch_sched.sv
// Directed bench for demux_dispatch_sched: dut_a (GAP_CYCLES=1) and
// dut_b (GAP_CYCLES=0), both DEPTH=4, share all inputs.
module tb_demux_dispatch_sched;

  logic       clk = 1'b0;
  logic       rst, en, flush, in_valid;
  logic [1:0] in_dest;

  logic       a_rdy, a_inp, a_busy, b_rdy, b_inp, b_busy;
  logic [1:0] a_sel, b_sel;
  logic [2:0] a_cnt, b_cnt;
`ifdef DISPATCH_CNT_EN
  logic [31:0] a_dc, b_dc;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_dispatch_sched #(.DEPTH(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .in_dest(in_dest), .in_ready(a_rdy), .sel(a_sel), .inp(a_inp),
    .fifo_count(a_cnt), .busy(a_busy)
`ifdef DISPATCH_CNT_EN
    , .disp_cnt(a_dc)
`endif
  );

  demux_dispatch_sched #(.DEPTH(4), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .in_dest(in_dest), .in_ready(b_rdy), .sel(b_sel), .inp(b_inp),
    .fifo_count(b_cnt), .busy(b_busy)
`ifdef DISPATCH_CNT_EN
    , .disp_cnt(b_dc)
`endif
  );

  typedef struct {
    logic       en, flush, vld;
    logic [1:0] dest;
    logic       e_inp;
    logic [1:0] e_sel;
    logic [2:0] e_cnt;
    logic       e_rdy, e_busy;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(input logic e, input logic v, input logic [1:0] d,
                              input logic ei, input logic [1:0] es,
                              input logic [2:0] ec, input logic er, input logic eb);
    vec_t r;
    r.en = e; r.flush = 1'b0; r.vld = v; r.dest = d;
    r.e_inp = ei; r.e_sel = es; r.e_cnt = ec; r.e_rdy = er; r.e_busy = eb;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; in_dest = 2'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push_one(input logic [1:0] d);
    in_valid = 1'b1; in_dest = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    // en vld dest | inp sel cnt rdy busy   (outputs after the edge)
    // single request, dest 2
    tbl[0]  = mk(1, 1, 2, 0, 0, 1, 1, 1);
    tbl[1]  = mk(1, 0, 0, 1, 2, 0, 1, 1);
    tbl[2]  = mk(1, 0, 0, 0, 2, 0, 1, 1);
    tbl[3]  = mk(1, 0, 0, 0, 2, 0, 1, 0);
    // burst 0,1,3 with one low cycle between pulses
    tbl[4]  = mk(1, 1, 0, 0, 2, 1, 1, 1);
    tbl[5]  = mk(1, 1, 1, 1, 0, 1, 1, 1);
    tbl[6]  = mk(1, 1, 3, 0, 0, 2, 1, 1);
    tbl[7]  = mk(1, 0, 0, 1, 1, 1, 1, 1);
    tbl[8]  = mk(1, 0, 0, 0, 1, 1, 1, 1);
    tbl[9]  = mk(1, 0, 0, 1, 3, 0, 1, 1);
    tbl[10] = mk(1, 0, 0, 0, 3, 0, 1, 1);
    tbl[11] = mk(1, 0, 0, 0, 3, 0, 1, 0);
    // fill with en=0: 1,2,3,0 accepted, 5th (2) refused
    tbl[12] = mk(0, 1, 1, 0, 3, 1, 1, 1);
    tbl[13] = mk(0, 1, 2, 0, 3, 2, 1, 1);
    tbl[14] = mk(0, 1, 3, 0, 3, 3, 1, 1);
    tbl[15] = mk(0, 1, 0, 0, 3, 4, 0, 1);
    tbl[16] = mk(0, 1, 2, 0, 3, 4, 0, 1);
    // enable: drains in FIFO order 1,2,3,0
    tbl[17] = mk(1, 0, 0, 1, 1, 3, 1, 1);
    tbl[18] = mk(1, 0, 0, 0, 1, 3, 1, 1);
    tbl[19] = mk(1, 0, 0, 1, 2, 2, 1, 1);
    tbl[20] = mk(1, 0, 0, 0, 2, 2, 1, 1);
    tbl[21] = mk(1, 0, 0, 1, 3, 1, 1, 1);
    tbl[22] = mk(1, 0, 0, 0, 3, 1, 1, 1);
    tbl[23] = mk(1, 0, 0, 1, 0, 0, 1, 1);
    tbl[24] = mk(1, 0, 0, 0, 0, 0, 1, 1);
    tbl[25] = mk(1, 0, 0, 0, 0, 0, 1, 0);

    // reset state
    do_reset();
    chk("rst_sel",  a_sel,  0);
    chk("rst_inp",  a_inp,  0);
    chk("rst_cnt",  a_cnt,  0);
    chk("rst_rdy",  a_rdy,  1);
    chk("rst_busy", a_busy, 0);
    chk("rst_b_inp", b_inp, 0);

    // table: single request, burst, full FIFO drain on dut_a
    for (int i = 0; i < 26; i++) begin
      en = tbl[i].en; flush = tbl[i].flush;
      in_valid = tbl[i].vld; in_dest = tbl[i].dest;
      step();
      chk($sformatf("v%0d_inp", i),  a_inp,  tbl[i].e_inp);
      chk($sformatf("v%0d_sel", i),  a_sel,  tbl[i].e_sel);
      chk($sformatf("v%0d_cnt", i),  a_cnt,  tbl[i].e_cnt);
      chk($sformatf("v%0d_rdy", i),  a_rdy,  tbl[i].e_rdy);
      chk($sformatf("v%0d_busy", i), a_busy, tbl[i].e_busy);
    end
    in_valid = 1'b0;

    // back-to-back on dut_b: 3,2,1,0 on consecutive cycles
    do_reset();
    push_one(3); push_one(2); push_one(1); push_one(0);
    chk("b2b_cnt", b_cnt, 4);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("b2b%0d_inp", i), b_inp, 1);
      chk($sformatf("b2b%0d_sel", i), b_sel, 3 - i);
      chk($sformatf("b2b%0d_cnt", i), b_cnt, 3 - i);
    end
    step();
    chk("b2b_end_inp",  b_inp,  0);
    chk("b2b_end_sel",  b_sel,  0);
    chk("b2b_end_busy", b_busy, 0);

    // flush during ISSUE on dut_a, with a push presented during flush
    do_reset();
    push_one(1); push_one(2); push_one(3);
    en = 1'b1;
    step();
    chk("fl_pre_inp", a_inp, 1);
    chk("fl_pre_sel", a_sel, 1);
    chk("fl_pre_cnt", a_cnt, 2);
    flush = 1'b1; in_valid = 1'b1; in_dest = 2'd0;
    #1;
    chk("fl_rdy", a_rdy, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_inp", a_inp, 0);
    chk("fl_cnt", a_cnt, 0);
    chk("fl_sel", a_sel, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("fl_post%0d_inp", i), a_inp, 0);
    end
    chk("fl_post_cnt",  a_cnt,  0);
    chk("fl_post_busy", a_busy, 0);

    // reset mid-pulse truncates and restores reset values
    do_reset();
    push_one(3); push_one(1);
    en = 1'b1;
    step();
    chk("rm_pre_inp", a_inp, 1);
    chk("rm_pre_sel", a_sel, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_inp",  a_inp,  0);
    chk("rm_sel",  a_sel,  0);
    chk("rm_cnt",  a_cnt,  0);
    chk("rm_busy", a_busy, 0);

    // en low during GAP: gap still runs out, next pulse waits for en
    do_reset();
    push_one(2); push_one(0);
    en = 1'b1;
    step();
    chk("eg_inp1", a_inp, 1);
    en = 1'b0;
    step();
    chk("eg_gap_inp", a_inp, 0);
    step();
    chk("eg_hold_inp", a_inp, 0);
    chk("eg_hold_cnt", a_cnt, 1);
    en = 1'b1;
    step();
    chk("eg_inp2", a_inp, 1);
    chk("eg_sel2", a_sel, 0);

`ifdef DISPATCH_CNT_EN
    // saturation: 300 pulses to ch1
    begin
      int pulses = 0;
      do_reset();
      chk("dc_rst", a_dc, 0);
      en = 1'b1; in_valid = 1'b1; in_dest = 2'd1;
      for (int c = 0; c < 2000 && pulses < 300; c++) begin
        step();
        if (a_inp) pulses++;
      end
      in_valid = 1'b0;
      chk("dc_pulses", pulses, 300);
      chk("dc_ch1", a_dc[15:8], 255);
      chk("dc_other", {a_dc[31:16], a_dc[7:0]}, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("dc_flush", a_dc, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
